// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array drain logic.
//   drain_state_e : one-hot drain FSM encoding (IDLE, DRAIN)
//   num_macs      : number of MACs in a width x height array
//   idx_width     : bit width of a word index over n words (never below 1)
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    DRAIN = 2'b10
  } drain_state_e;

  function automatic int num_macs(input int array_width, input int array_height);
    return array_width * array_height;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z_serializer_counter.sv
// Word index counter for the result drain.
// Ports:
//   clk_i    in   clock
//   reset_i  in   asynchronous active-high reset, count -> 0
//   clear_i  in   synchronous clear, wins over en_i
//   en_i     in   increment by one
//   count_o  out  current count
module z_serializer_counter
  import sa_pkg::*;
#(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/z_serializer.sv
// Drain end of the systolic array. Snapshots the packed MAC result bus once
// every MAC reports valid, acknowledges all MACs in that same cycle, then
// streams the words out one per beat on a valid/yumi producer interface.
//
// Build option: Z_SERIALIZER_TRANSPOSE_EN
//   defined   : words leave column-major (column outer, row inner)
//   undefined : words leave row-major (MAC index order)
//
// Ports:
//   clk_i      in   clock
//   reset_i    in   asynchronous active-high reset
//   en_i       in   global enable; low freezes all state
//   z_i        in   packed results, MAC k at [k*width_p +: width_p]
//   z_valid_i  in   per-MAC result valid
//   z_yumi_o   out  per-MAC result consumed (single-cycle, all bits together)
//   valid_o    out  data_o holds a result
//   yumi_i     in   downstream takes data_o this cycle
//   data_o     out  current result word
//   last_o     out  data_o is the final word of the matrix
//   busy_o     out  drain in progress
module z_serializer
  import sa_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_i,
  input  logic                                                 en_i,
  input  logic [width_p*num_macs(array_width_p,array_height_p)-1:0] z_i,
  input  logic [num_macs(array_width_p,array_height_p)-1:0]    z_valid_i,
  output logic [num_macs(array_width_p,array_height_p)-1:0]    z_yumi_o,
  output logic                                                 valid_o,
  input  logic                                                 yumi_i,
  output logic [width_p-1:0]                                   data_o,
  output logic                                                 last_o,
  output logic                                                 busy_o
);

  localparam int num_macs_lp = num_macs(array_width_p, array_height_p);
  localparam int idx_w_lp    = idx_width(num_macs_lp);
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_macs_lp - 1);

  drain_state_e          state_r, state_n;
  logic [width_p-1:0]    shadow_r [num_macs_lp];
  logic [idx_w_lp-1:0]   idx_r;
  logic [width_p-1:0]    word_w;
  logic                  capture_w;
  logic                  take_w;
  logic                  last_w;

  // Output sequence position at which MAC k is emitted. The mux below
  // compares idx_r against this per MAC, so any array shape works.
  function automatic logic [idx_w_lp-1:0] seq_of(input int k);
`ifdef Z_SERIALIZER_TRANSPOSE_EN
    return idx_w_lp'((k % array_width_p) * array_height_p + (k / array_width_p));
`else
    return idx_w_lp'(k);
`endif
  endfunction

  assign valid_o = (state_r == DRAIN);
  assign busy_o  = (state_r != IDLE);
  assign last_w  = valid_o && (idx_r == last_idx_lp);
  assign last_o  = last_w;
  assign take_w  = en_i & yumi_i & valid_o;

  // All MACs are acked together in the capture cycle itself.
  assign z_yumi_o = {num_macs_lp{capture_w}};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Every transition is already qualified by en_i, so no enable on the register.
  always_comb begin
    state_n   = state_r;
    capture_w = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_i && (&z_valid_i)) begin
          capture_w = 1'b1;
          state_n   = DRAIN;
        end
      end
      DRAIN: begin
        if (take_w && last_w) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_macs_lp; k++) begin
        shadow_r[k] <= '0;
      end
    end else if (capture_w) begin
      for (int k = 0; k < num_macs_lp; k++) begin
        shadow_r[k] <= z_i[k*width_p +: width_p];
      end
    end
  end

  // Index restarts on capture and after the last beat leaves.
  z_serializer_counter #(
    .width_p (idx_w_lp)
  ) idx_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (capture_w | (take_w & last_w)),
    .en_i    (take_w),
    .count_o (idx_r)
  );

  always_comb begin
    word_w = '0;
    for (int k = 0; k < num_macs_lp; k++) begin
      if (idx_r == seq_of(k)) begin
        word_w = shadow_r[k];
      end
    end
  end

  // Bus reads zero whenever nothing is being offered.
  assign data_o = valid_o ? word_w : '0;

`ifndef SYNTHESIS
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> valid_o)
    else $error("z_serializer: yumi_i asserted without valid_o");
`endif

endmodule

// File: tb/tb_z_serializer.sv
module tb_z_serializer;

  localparam int WIDTH = 32;
`ifdef Z_SERIALIZER_TRANSPOSE_EN
  localparam int AW = 3;
  localparam int AH = 2;
`else
  localparam int AW = 2;
  localparam int AH = 2;
`endif
  localparam int NUM = AW * AH;
  localparam logic [NUM-1:0] ALL = '1;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 en_i;
  logic [NUM*WIDTH-1:0] z_i;
  logic [NUM-1:0]       z_valid_i;
  logic [NUM-1:0]       z_yumi_o;
  logic                 valid_o;
  logic                 yumi_i;
  logic [WIDTH-1:0]     data_o;
  logic                 last_o;
  logic                 busy_o;

  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               cyc;

  z_serializer #(
    .width_p        (WIDTH),
    .array_width_p  (AW),
    .array_height_p (AH)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .z_i       (z_i),
    .z_valid_i (z_valid_i),
    .z_yumi_o  (z_yumi_o),
    .valid_o   (valid_o),
    .yumi_i    (yumi_i),
    .data_o    (data_o),
    .last_o    (last_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MAC index emitted at output position s.
  function automatic int mac_of_seq(input int s);
`ifdef Z_SERIALIZER_TRANSPOSE_EN
    int c;
    int r;
    c = s / AH;
    r = s % AH;
    return r * AW + c;
`else
    return s;
`endif
  endfunction

  task automatic capture(input int base);
    @(negedge clk_i);
    for (int k = 0; k < NUM; k++) z_i[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    z_valid_i = ALL;
    en_i      = 1'b1;
    yumi_i    = 1'b0;
    #1;
    chk("zyumi_capture", 32'(z_yumi_o), 32'(ALL));
    chk("valid_before_capture", 32'(valid_o), 0);
    for (int s = 0; s < NUM; s++) exp_q.push_back(z_i[mac_of_seq(s)*WIDTH +: WIDTH]);
  endtask

  // mode 0: take every offered word; mode 1: yumi alternates 0/1 starting at 0.
  task automatic drain(input int mode, input int stop, output int cycles);
    int guard;
    int taken;
    bit ph;
    guard  = 0;
    taken  = 0;
    ph     = 1'b0;
    cycles = 0;
    while (exp_q.size() > 0 && taken < stop && guard < 8*NUM + 8) begin
      @(negedge clk_i);
      guard++;
      chk("valid", 32'(valid_o), 1);
      if (guard == 1) chk("zyumi_in_drain", 32'(z_yumi_o), 0);
      z_valid_i = '0;
      if (valid_o) begin
        cycles++;
        chk("data", data_o, exp_q[0]);
        chk("last", 32'(last_o), 32'(exp_q.size() == 1));
        if (mode == 0 || ph) begin
          yumi_i = 1'b1;
          void'(exp_q.pop_front());
          taken++;
        end else begin
          yumi_i = 1'b0;
        end
        ph = ~ph;
      end else begin
        yumi_i = 1'b0;
      end
    end
    chk("drain_taken", taken, stop);
    if (exp_q.size() == 0) begin
      @(negedge clk_i);
      yumi_i = 1'b0;
      chk("valid_after", 32'(valid_o), 0);
      chk("busy_after", 32'(busy_o), 0);
      chk("last_after", 32'(last_o), 0);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    en_i      = 1'b0;
    yumi_i    = 1'b0;
    z_i       = '0;
    z_valid_i = '0;

    // reset state
    @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_zyumi", 32'(z_yumi_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // 1: straight drain
    capture(1);
    drain(0, NUM, cyc);
    chk("t1_cycles", cyc, NUM);

    // 2: alternating backpressure, each word held until taken
    capture(1);
    drain(1, NUM, cyc);
    chk("t2_cycles", cyc, 2*NUM);

    // 3: partial valid never captures
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      z_valid_i = ALL >> 1;
      en_i      = 1'b1;
      #1;
      chk("t3_zyumi", 32'(z_yumi_o), 0);
      chk("t3_valid", 32'(valid_o), 0);
      chk("t3_busy", 32'(busy_o), 0);
    end
    capture(1);
    drain(0, NUM, cyc);

    // 4: reset after two words, then a fresh matrix starts at its first word
    capture(1);
    drain(0, 2, cyc);
    @(negedge clk_i);
    yumi_i    = 1'b0;
    z_valid_i = '0;
    reset_i   = 1'b1;
    #1;
    chk("t4_valid", 32'(valid_o), 0);
    chk("t4_last", 32'(last_o), 0);
    chk("t4_busy", 32'(busy_o), 0);
    exp_q.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    capture(20);
    drain(0, NUM, cyc);

    // 5: enable low blocks capture in IDLE and advance in DRAIN
    @(negedge clk_i);
    en_i      = 1'b0;
    z_valid_i = ALL;
    #1;
    chk("t5_zyumi_en0", 32'(z_yumi_o), 0);
    @(negedge clk_i);
    chk("t5_busy_en0", 32'(busy_o), 0);
    chk("t5_valid_en0", 32'(valid_o), 0);
    capture(1);
    drain(0, 1, cyc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t5_valid_hold", 32'(valid_o), 1);
      chk("t5_data_hold", data_o, exp_q[0]);
      en_i   = 1'b0;
      yumi_i = 1'b1;
    end
    @(negedge clk_i);
    chk("t5_data_after", data_o, exp_q[0]);
    chk("t5_last_after", 32'(last_o), 32'(exp_q.size() == 1));
    yumi_i = 1'b0;
    en_i   = 1'b1;
    drain(0, NUM-1, cyc);

    // 6: distinct words 10.. expose output ordering
    capture(10);
    drain(0, NUM, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
